ir_receiver: RTL



---
 rtl/ir_receiver.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ir_receiver.sv
// NEC-style IR frame decoder: synchronizes the sensor, measures mark/space lengths
// in half-unit ticks and raises irIrq with the decoded command. Optional: IR_REPEAT_EN.
module ir_receiver #(
  parameter int CLKS_PER_UNIT = 28125,
  parameter bit INVERT_IN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       irIn,
  input  logic       irResponse,
  output logic       irIrq,
  output logic [3:0] irData,
  output logic [7:0] irCommand,
  output logic [7:0] irAddr,
  output logic       frameError
);

  localparam int HALF = CLKS_PER_UNIT / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LDR_MARK  = 3'd1;
  localparam logic [2:0] S_LDR_SPACE = 3'd2;
  localparam logic [2:0] S_BIT_MARK  = 3'd3;
  localparam logic [2:0] S_BIT_SPACE = 3'd4;
  localparam logic [2:0] S_STOP_MARK = 3'd5;

  logic          s1_q, s2_q, mark_q;
  logic          mark_w, edge_w, wrap_w;
  logic [PW-1:0] pre_q;
  logic [5:0]    hu_q;
  logic [2:0]    state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [31:0]   sr_q, sr_d;
  logic          err_w, acc_w, rep_w, rep_ok_w;
  logic          irq_q, ferr_q;
  logic [7:0]    cmd_q, addr_q;

  function automatic logic in_rng(input logic [5:0] v, input logic [5:0] lo,
                                  input logic [5:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Synchronizer idles at the space level so reset never fakes a mark edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= INVERT_IN;
      s2_q   <= INVERT_IN;
      mark_q <= 1'b0;
    end else begin
      s1_q   <= irIn;
      s2_q   <= s1_q;
      mark_q <= mark_w;
    end
  end

  assign mark_w = INVERT_IN ? ~s2_q : s2_q;
  assign edge_w = mark_w ^ mark_q;
  assign wrap_w = (pre_q == PW'(HALF - 1));

  always_ff @(posedge clk) begin
    if (rst || edge_w) begin
      pre_q <= '0;
      hu_q  <= '0;
    end else if (wrap_w) begin
      pre_q <= '0;
      if (hu_q != 6'd63) hu_q <= hu_q + 6'd1;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  // Every edge seen outside IDLE ends the phase the current state is timing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    err_w   = 1'b0;
    acc_w   = 1'b0;
    rep_w   = 1'b0;
    if (edge_w) begin
      case (state_q)
        S_IDLE:      if (mark_w) state_d = S_LDR_MARK;
        S_LDR_MARK:  if (in_rng(hu_q, 6'd28, 6'd36)) state_d = S_LDR_SPACE;
                     else err_w = 1'b1;
        S_LDR_SPACE: begin
          if (in_rng(hu_q, 6'd14, 6'd18)) begin
            state_d = S_BIT_MARK;
            idx_d   = '0;
            sr_d    = '0;
          end else if (in_rng(hu_q, 6'd6, 6'd10)) begin
            state_d = S_STOP_MARK;
          end else begin
            err_w = 1'b1;
          end
        end
        S_BIT_MARK: begin
          if (!in_rng(hu_q, 6'd1, 6'd3)) begin
            err_w = 1'b1;
          end else if (idx_q == 6'd32) begin
            state_d = S_IDLE;
            if (sr_q[15:8] == ~sr_q[7:0] && sr_q[31:24] == ~sr_q[23:16]) acc_w = 1'b1;
            else err_w = 1'b1;
          end else begin
            state_d = S_BIT_SPACE;
          end
        end
        S_BIT_SPACE: begin
          if (in_rng(hu_q, 6'd1, 6'd3) || in_rng(hu_q, 6'd5, 6'd8)) begin
            sr_d    = {in_rng(hu_q, 6'd5, 6'd8), sr_q[31:1]};
            idx_d   = idx_q + 6'd1;
            state_d = S_BIT_MARK;
          end else begin
            err_w = 1'b1;
          end
        end
        S_STOP_MARK: begin
          if (in_rng(hu_q, 6'd1, 6'd3)) begin
            rep_w   = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_w = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && hu_q >= 6'd40) begin
      err_w = 1'b1;
    end
    if (err_w) state_d = S_IDLE;
  end

`ifdef IR_REPEAT_EN
  logic have_q;
  always_ff @(posedge clk) begin
    if (rst)        have_q <= 1'b0;
    else if (acc_w) have_q <= 1'b1;
  end
  assign rep_ok_w = have_q;
`else
  assign rep_ok_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sr_q    <= '0;
      irq_q   <= 1'b0;
      ferr_q  <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      ferr_q  <= err_w;
      // A fresh accept beats a same-cycle acknowledge.
      if (acc_w) begin
        addr_q <= sr_q[7:0];
        cmd_q  <= sr_q[23:16];
        irq_q  <= 1'b1;
      end else if (rep_w && rep_ok_w) begin
        irq_q  <= 1'b1;
      end else if (irResponse) begin
        irq_q  <= 1'b0;
      end
    end
  end

  assign irIrq      = irq_q;
  assign irData     = cmd_q[3:0];
  assign irCommand  = cmd_q;
  assign irAddr     = addr_q;
  assign frameError = ferr_q;

endmodule
